// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide data memory with a single write enable.
// Loads are sized and extended on capture. Sub-word stores are done as
// read-modify-write so that the other lanes of the word are preserved.
module mem_access_unit #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_m_o,
    input  logic [31:0]       rdata_m_i
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP, ERR} state_t;

    state_t            state, nxt;
    logic              wr_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic        accept, illegal, misal, bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext, merged;

    // Byte-address bits above the memory size wrap and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

    assign accept       = req_valid_i && (state == IDLE);
    assign resp_rdata_o = rdata_q;

    // Classify the incoming request: illegal size code or misaligned address.
    always_comb begin
        illegal = 1'b0;
        misal   = 1'b0;
        if (req_write_i)
            illegal = (req_funct3_i > 3'b010);
        else
            illegal = !(req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (req_funct3_i[1:0])
            2'b01:   misal = req_addr_i[0];
            2'b10:   misal = (req_addr_i[1:0] != 2'b00);
            default: misal = 1'b0;
        endcase
        bad = illegal || misal;
    end

    // Lane selection for loads and lane insertion for sub-word stores.
    always_comb begin
        byte_sel = rdata_m_i[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? rdata_m_i[31:16] : rdata_m_i[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = rdata_m_i;
        endcase
        merged = rdata_m_i;
        if (f3_q[0])
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state and strobe decode; strobes come straight from state so they
    // drop the instant reset is asserted.
    always_comb begin
        nxt          = state;
        req_ready_o  = 1'b0;
        MemRead_o    = 1'b0;
        MemWrite_o   = 1'b0;
        addr_o       = '0;
        wdata_m_o    = '0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (accept) begin
                    if (bad)                                    nxt = ERR;
                    else if (req_write_i && req_funct3_i == 3'b010) nxt = WR;
                    else                                        nxt = RD;
                end
            end
            RD: begin
                MemRead_o = 1'b1;
                addr_o    = addr_q;
                nxt       = CAP;
            end
            CAP: begin
                addr_o = addr_q;
                nxt    = wr_q ? WR : RESP;
            end
            WR: begin
                MemWrite_o = 1'b1;
                addr_o     = addr_q;
                wdata_m_o  = wdata_q;
                nxt        = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                nxt          = IDLE;
            end
            ERR: begin
                resp_valid_o = 1'b1;
                resp_err_o   = 1'b1;
                nxt          = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Request latch, RMW merge buffer and response data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= req_write_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i[ADDR_W+1:2];
                off_q   <= req_addr_i[1:0];
                wdata_q <= req_wdata_i;
                if (bad) rdata_q <= '0;
            end
            if (state == CAP) begin
                if (wr_q) wdata_q <= merged;
                else      rdata_q <= load_ext;
            end
            if (state == WR) rdata_q <= '0;
        end
    end

endmodule
